// File: rtl/agc_uplink_pkg.sv
// Shared definitions for the INLINK uplink transmitter: FSM state encoding,
// default word/timing constants and the frame-length helper.
package agc_uplink_pkg;

  localparam int unsigned WORD_W_DEF  = 15;
  localparam int unsigned GAP_CYC_DEF = 8;
  localparam int unsigned ACK_TMO_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  // Number of bits shifted out per word: data bits plus an optional parity bit.
  function automatic int unsigned frame_len(input int unsigned word_w,
                                            input bit          parity_en);
    return parity_en ? (word_w + 1) : word_w;
  endfunction

endpackage

// File: rtl/uplink_tx_timer.sv
// Loadable down-counter with a zero flag. One instance is shared between
// the inter-bit gap and the acknowledge timeout, which never overlap.
module uplink_tx_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // Load has priority over decrement; the counter holds at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/uplink_tx.sv
// Uplink word transmitter: serialises a loaded word MSB first as
// INLNKP (one) / INLNKM (zero) increment requests to the INLINK counter
// cell, waiting for C45R acknowledge or timing out, with a fixed idle
// gap between bits.
// Build option: define UPLINK_TX_PARITY_EN to append an odd-parity bit.
module uplink_tx
  import agc_uplink_pkg::*;
#(
  parameter int unsigned WORD_W  = WORD_W_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF,
  parameter int unsigned ACK_TMO = ACK_TMO_DEF
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              LOAD,
  input  logic [WORD_W-1:0] DATA,
  input  logic              C45R,
  output logic              INLNKP,
  output logic              INLNKM,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVRN,
  output logic              TMOERR
);

`ifdef UPLINK_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int unsigned FRAME_W = frame_len(WORD_W, PARITY_EN);
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned TMR_MAX = (ACK_TMO > GAP_CYC) ? ACK_TMO : GAP_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  // Timer holds "cycles remaining minus one", so zero marks the last cycle.
  localparam logic [TMR_W-1:0] TMR_ACK = TMR_W'(ACK_TMO - 1);
  localparam logic [TMR_W-1:0] TMR_GAP = TMR_W'(GAP_CYC - 1);

  tx_state_e           state_q;
  logic [FRAME_W-1:0]  shreg_q;
  logic [CNT_W-1:0]    bits_q;
  logic                inlnkp_q;
  logic                inlnkm_q;
  logic                busy_q;
  logic                done_q;
  logic                ovrn_q;
  logic                tmoerr_q;

  logic [FRAME_W-1:0]  frame_word;
  logic                bit_ack;
  logic                bit_tmo;
  logic                tmr_load;
  logic                tmr_dec;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_zero;

`ifdef UPLINK_TX_PARITY_EN
  // Parity bit makes the total count of ones in the frame odd.
  assign frame_word = {DATA, ~^DATA};
`else
  assign frame_word = DATA;
`endif

  uplink_tx_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i  (CLOCK),
    .rst_i  (rst),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  // Decode bit completion and drive the shared timer for the current phase.
  // Acknowledge wins over timeout when both land in the same cycle.
  always_comb begin
    bit_ack  = 1'b0;
    bit_tmo  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (LOAD) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_ACK;
        end
      end
      ST_REQ: begin
        if (C45R) begin
          bit_ack  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_GAP;
        end else if (tmr_zero) begin
          bit_tmo  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_GAP;
        end else begin
          tmr_dec  = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          if (bits_q != '0) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_ACK;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Transmit FSM with registered request and status outputs.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bits_q   <= '0;
      inlnkp_q <= 1'b0;
      inlnkm_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovrn_q   <= 1'b0;
      tmoerr_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovrn_q <= LOAD && busy_q;
      case (state_q)
        ST_IDLE: begin
          if (LOAD) begin
            shreg_q  <= frame_word;
            bits_q   <= CNT_W'(FRAME_W);
            busy_q   <= 1'b1;
            tmoerr_q <= 1'b0;
            inlnkp_q <= frame_word[FRAME_W-1];
            inlnkm_q <= ~frame_word[FRAME_W-1];
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A timed-out bit is treated as sent so the word still completes.
          if (bit_ack || bit_tmo) begin
            inlnkp_q <= 1'b0;
            inlnkm_q <= 1'b0;
            shreg_q  <= {shreg_q[FRAME_W-2:0], 1'b0};
            bits_q   <= bits_q - CNT_W'(1);
            state_q  <= ST_GAP;
            if (bit_tmo) begin
              tmoerr_q <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            if (bits_q == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              inlnkp_q <= shreg_q[FRAME_W-1];
              inlnkm_q <= ~shreg_q[FRAME_W-1];
              state_q  <= ST_REQ;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign INLNKP = inlnkp_q;
  assign INLNKM = inlnkm_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign OVRN   = ovrn_q;
  assign TMOERR = tmoerr_q;

endmodule
